dense_result_streamer: RTL
==========================

Name: dense_result_streamer

Overview:
Output-side consumer for the dense layer. On the dense layer's completion indication (rising edge of its resting signal) it snapshots the flat 16*n-bit result vector y. It then streams the result one signed 16-bit word per beat over a valid/ready interface to the next stage (next layer loader, DMA or host readback). It decouples the dense layer's parallel result bus from serial downstream consumers, so the dense layer may start its next computation as soon as the snapshot is taken.

Parameters:
n, 100, number of result words in the flat input vector (n >= 2)
W, 16, word width in bits; signed fixed-point (Q1.15 in the default configuration)
IW, $clog2(n), index width for word counter and argmax index

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
y_in  input  W*n  flat result vector from dense layer; word j = y_in[W*(j+1)-1 -: W]
resting_in  input  1  dense layer completion level; a 0->1 transition means y_in is valid this cycle
out_data  output  W  current result word (signed)
out_idx  output  IW  index j of out_data
out_valid  output  1  out_data/out_idx/out_last valid
out_ready  input  1  downstream accepts the beat when out_valid && out_ready
out_last  output  1  high with the beat for index n-1
busy  output  1  snapshot held and not fully streamed
done  output  1  one-cycle pulse in the cycle after the final beat is accepted
overrun  output  1  sticky: a new completion edge arrived while busy
argmax_idx  output  IW  see Optional Feature
argmax_val  output  W  see Optional Feature

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE. out_valid=0, out_last=0, busy=0, done=0, overrun=0, out_idx=0, out_data=0, shadow register cleared, argmax outputs 0. The edge-detect register resting_q resets to 1, so a resting_in already high at reset release is not an edge; a real 0->1 transition is required.
- Edge detection: rise = resting_in && !resting_q; resting_q <= resting_in every cycle.
- States: IDLE and STREAM.
- IDLE: on rise, shadow <= y_in, idx <= 0, go to STREAM. out_valid=1 and busy=1 are registered at that same edge, so the first beat is presented 1 cycle after the sampled edge.
- STREAM: out_valid=1, out_data=shadow word idx, out_idx=idx, out_last=(idx==n-1).
  - Beat accepted (out_valid && out_ready): if idx<n-1, idx++; else go to IDLE, out_valid<=0, busy<=0, done<=1 for one cycle.
  - No accept: out_data, out_idx and out_last are held stable; out_valid never drops before acceptance.
  - Throughput: 1 word/cycle with out_ready held high, n cycles per vector.
- Rise while in STREAM, including the cycle of the last accept: the new vector is dropped, overrun<=1 (sticky until rst), and the current stream continues unchanged.
- Rise in the cycle done is high: state is IDLE, so the new vector is captured normally.
- Reset mid-stream: immediate return to reset values. The partial stream is abandoned with no done pulse.
- y_in is sampled only on the capture edge; later changes to y_in do not affect the stream.
- No arithmetic is performed on the data path; words pass through bit-exact, so negative values keep their two's-complement encoding.

Optional Feature:
Macro STREAMER_ARGMAX_EN.
- Defined: running signed maximum over accepted beats. On the first beat of a vector, best <= word 0. Later beats replace best only if strictly greater, so ties keep the lowest index. argmax_idx and argmax_val update in the same cycle done pulses and hold until the next done or rst.
- Not defined: argmax_idx and argmax_val are tied to 0, no comparator is synthesised, and the ports remain present so instantiations are unchanged.

Test Plan:
- Basic (n=10): y_in words j=0..9 = 1..10, pulse resting_in 0->1, out_ready=1 -> out_data 1,2,...,10 on 10 consecutive cycles starting 1 cycle after the edge; out_last only on 10; done 1 cycle after the 10th beat; busy low after.
- Backpressure: same vector, out_ready pattern 1,0,0,1,0,1... -> out_data held at 2 during the stall cycles, no word skipped or duplicated, 10 beats total.
- Negative data: word 3 = -5 (0xFFFB), word 7 = -32768 (0x8000) -> streamed bit-exact; y_in changed to all zeros after capture -> stream unaffected.
- Overrun: second 0->1 on resting_in while streaming word 4 -> current stream completes with the original values, overrun=1 and stays 1; a 0->1 after done -> new vector captured, overrun still 1 until rst.
- Reset mid-stream: rst at word 5 -> next cycle out_valid=0, busy=0, overrun=0, no done. resting_in held high through reset release -> no capture until it falls and rises again.
- ARGMAX (macro defined): words 1,9,-3,9,2,... -> argmax_idx=1, argmax_val=9 with done. With the macro undefined -> both outputs 0.

Source files
------------

// File: rtl/dense_result_streamer.sv
// Snapshots the dense layer's flat result vector on its completion edge and streams it word by word over valid/ready.
// Optional running argmax over the streamed words is enabled by defining STREAMER_ARGMAX_EN.
module dense_result_streamer #(
    parameter int n  = 100,
    parameter int W  = 16,
    parameter int IW = $clog2(n)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W*n-1:0] y_in,
    input  logic           resting_in,
    output logic [W-1:0]   out_data,
    output logic [IW-1:0]  out_idx,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_last,
    output logic           busy,
    output logic           done,
    output logic           overrun,
    output logic [IW-1:0]  argmax_idx,
    output logic [W-1:0]   argmax_val
);
    // state  | meaning
    // IDLE   | no snapshot held, waiting for a 0->1 on resting_in
    // STREAM | snapshot held, presenting word idx_q until accepted
    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(n - 1);

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [W-1:0]   shadow_q [n];
    logic           resting_q;
    logic           done_q, done_d;
    logic           overrun_q, overrun_d;
    logic           rise, accept, capture;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;
        capture   = 1'b0;
        rise      = resting_in && !resting_q;
        accept    = (state_q == STREAM) && out_ready;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    capture = 1'b1;
                    idx_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                // A completion edge while streaming is dropped, even on the final accept
                if (rise) overrun_d = 1'b1;
                if (accept) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            resting_q <= 1'b1;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int j = 0; j < n; j++) shadow_q[j] <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            resting_q <= resting_in;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            if (capture) begin
                for (int j = 0; j < n; j++) shadow_q[j] <= y_in[W*j +: W];
            end
        end
    end

    assign out_valid = (state_q == STREAM);
    assign busy      = (state_q == STREAM);
    assign out_data  = shadow_q[idx_q];
    assign out_idx   = idx_q;
    assign out_last  = (state_q == STREAM) && (idx_q == LAST_IDX);
    assign done      = done_q;
    assign overrun   = overrun_q;

`ifdef STREAMER_ARGMAX_EN
    logic [W-1:0]  best_val_q, amax_val_q, cand_val;
    logic [IW-1:0] best_idx_q, amax_idx_q, cand_idx;

    // Strictly-greater replacement keeps the lowest index on ties
    always_comb begin
        cand_val = best_val_q;
        cand_idx = best_idx_q;
        if (idx_q == '0 || $signed(out_data) > $signed(best_val_q)) begin
            cand_val = out_data;
            cand_idx = idx_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            best_val_q <= '0;
            best_idx_q <= '0;
            amax_val_q <= '0;
            amax_idx_q <= '0;
        end else if (accept) begin
            best_val_q <= cand_val;
            best_idx_q <= cand_idx;
            if (idx_q == LAST_IDX) begin
                amax_val_q <= cand_val;
                amax_idx_q <= cand_idx;
            end
        end
    end

    assign argmax_idx = amax_idx_q;
    assign argmax_val = amax_val_q;
`else
    assign argmax_idx = '0;
    assign argmax_val = '0;
`endif

endmodule
